// File: rtl/mod_horner_reducer.sv
// mod_horner_reducer
//   Streams a wide operand in as CHUNK_W-bit digits, most-significant digit
//   first, and reduces it modulo MOD with the Horner recurrence
//     acc <= (acc * 2^CHUNK_W + digit) mod MOD
//   one digit per cycle. The finished residue and the digit count are offered
//   on a valid/ready output and held stable until the consumer takes them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   digit present
//   in_ready   block can accept a digit (low only while a result is pending)
//   in_digit   operand digit, MS digit first
//   in_first   digit opens a new operand (abandons any open operand)
//   in_last    digit closes the operand
//   out_valid  residue available
//   out_ready  consumer accepts residue
//   out_res    operand mod MOD, always < MOD
//   out_len    digits in operand, saturating at 2^LEN_W-1
module mod_horner_reducer #(
  parameter int unsigned MOD     = 461,
  parameter int unsigned RES_W   = 9,
  parameter int unsigned CHUNK_W = 6,
  parameter int unsigned LEN_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CHUNK_W-1:0] in_digit,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_res,
  output logic [LEN_W-1:0]   out_len
);

  // acc < MOD, so acc * 2^CHUNK_W + digit < 2^(RES_W+CHUNK_W) always fits.
  localparam int unsigned W = RES_W + CHUNK_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [RES_W-1:0]   acc;
  logic [RES_W-1:0]   acc_nxt;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   cnt_nxt;
  logic               in_xfer;
  logic               new_op;
  logic [RES_W-1:0]   base;
  logic [W-1:0]       red;

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);
  assign out_res   = acc;
  assign out_len   = cnt;

  assign in_xfer = in_valid & in_ready;
  // A digit arriving with no operand open starts one even without in_first.
  assign new_op  = in_first | (state == IDLE);
  assign base    = new_op ? '0 : acc;

  // Single-cycle reduction: the shifted value is below 2*MOD*2^CHUNK_W, so one
  // conditional subtract of MOD*2^k per k = CHUNK_W..0 halves the bound each
  // stage and leaves a value below MOD. Also covers digits >= MOD.
  always_comb begin
    red = {base, in_digit};
    for (int unsigned i = 0; i <= CHUNK_W; i++) begin
      if (red >= (W'(MOD) << (CHUNK_W - i))) begin
        red = red - (W'(MOD) << (CHUNK_W - i));
      end
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    if (in_xfer) begin
      acc_nxt = RES_W'(red);
      if (new_op) begin
        cnt_nxt = LEN_W'(1);
      end else if (cnt != '1) begin
        cnt_nxt = cnt + LEN_W'(1);
      end
    end
    case (state)
      IDLE, ACCUM: begin
        if (in_xfer) begin
          state_nxt = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mod_horner_reducer.sv
// Directed bench for mod_horner_reducer: default instance (MOD=461, CHUNK_W=6)
// plus a small-modulus instance (MOD=3, CHUNK_W=4, LEN_W=4) where digits
// exceed the modulus and the length counter saturates quickly.
module tb_mod_horner_reducer;

  logic       clk;
  logic       rst_n;

  logic       a_in_valid, a_in_ready, a_in_first, a_in_last;
  logic [5:0] a_in_digit;
  logic       a_out_valid, a_out_ready;
  logic [8:0] a_out_res;
  logic [7:0] a_out_len;

  logic       b_in_valid, b_in_ready, b_in_first, b_in_last;
  logic [3:0] b_in_digit;
  logic       b_out_valid, b_out_ready;
  logic [1:0] b_out_res;
  logic [3:0] b_out_len;

  int checks;
  int failures;

  mod_horner_reducer #(.MOD(461), .RES_W(9), .CHUNK_W(6), .LEN_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_digit(a_in_digit),
    .in_first(a_in_first), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_res(a_out_res), .out_len(a_out_len)
  );

  mod_horner_reducer #(.MOD(3), .RES_W(2), .CHUNK_W(4), .LEN_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_digit(b_in_digit),
    .in_first(b_in_first), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_res(b_out_res), .out_len(b_out_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one digit and returns #1 after the edge that takes it.
  task automatic send_a(input logic [5:0] d, input logic f, input logic l);
    int guard;
    guard = 0;
    a_in_valid = 1'b1; a_in_digit = d; a_in_first = f; a_in_last = l;
    while (!a_in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      failures++; $display("FAIL send_a_ready_timeout actual=%b required=1", a_in_ready);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_first = 1'b0; a_in_last = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] d, input logic f, input logic l);
    int guard;
    guard = 0;
    b_in_valid = 1'b1; b_in_digit = d; b_in_first = f; b_in_last = l;
    while (!b_in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    checks++;
    if (b_in_ready !== 1'b1) begin
      failures++; $display("FAIL send_b_ready_timeout actual=%b required=1", b_in_ready);
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_first = 1'b0; b_in_last = 1'b0;
  endtask

  task automatic pop_a;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_res, a_out_len} !== {1'b0, 1'b1, 9'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_state actual v=%b rdy=%b res=%0d len=%0d required v=0 rdy=1 res=0 len=0",
               a_out_valid, a_in_ready, a_out_res, a_out_len);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    send_a(6'd63, 1'b1, 1'b1);
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      failures++; $display("FAIL single_valid actual v=%b rdy=%b required v=1 rdy=0", a_out_valid, a_in_ready);
    end
    checks++;
    if (a_out_res !== 9'd63 || a_out_len !== 8'd1) begin
      failures++; $display("FAIL single_result actual res=%0d len=%0d required res=63 len=1", a_out_res, a_out_len);
    end
    pop_a;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      failures++; $display("FAIL single_pop actual v=%b rdy=%b required v=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  // Operands back to back with out_ready held high.
  task automatic test_back_to_back;
    int          nd  [4] = '{2, 2, 2, 3};
    logic [5:0]  dg  [4][3] = '{'{6'd7, 6'd13, 6'd0}, '{6'd1, 6'd0, 6'd0},
                                '{6'd63, 6'd63, 6'd0}, '{6'd63, 6'd63, 6'd63}};
    logic [8:0]  exr [4] = '{9'd0, 9'd64, 9'd407, 9'd295};
    a_out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int j = 0; j < nd[op]; j++) begin
        send_a(dg[op][j], j == 0, j == nd[op] - 1);
      end
      checks++;
      if (a_out_valid !== 1'b1 || a_out_res !== exr[op] || a_out_len !== 8'(nd[op])) begin
        failures++;
        $display("FAIL b2b_op%0d actual v=%b res=%0d len=%0d required v=1 res=%0d len=%0d",
                 op, a_out_valid, a_out_res, a_out_len, exr[op], nd[op]);
      end
      @(posedge clk); #1;
    end
    a_out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int bad;
    send_a(6'd63, 1'b1, 1'b0);
    send_a(6'd63, 1'b0, 1'b0);
    send_a(6'd63, 1'b0, 1'b1);
    // Next operand is presented while the result is pending and must wait.
    a_in_valid = 1'b1; a_in_digit = 6'd5; a_in_first = 1'b1; a_in_last = 1'b1;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if ({a_out_valid, a_in_ready, a_out_res, a_out_len} !== {1'b1, 1'b0, 9'd295, 8'd3}) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL backpressure_hold actual bad_cycles=%0d required=0 (res=%0d len=%0d)",
                           bad, a_out_res, a_out_len);
    end
    pop_a;
    checks++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      failures++; $display("FAIL backpressure_release actual v=%b rdy=%b required v=0 rdy=1", a_out_valid, a_in_ready);
    end
    send_a(6'd5, 1'b1, 1'b1);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_res !== 9'd5 || a_out_len !== 8'd1) begin
      failures++; $display("FAIL bubble_next actual v=%b res=%0d len=%0d required v=1 res=5 len=1",
                           a_out_valid, a_out_res, a_out_len);
    end
    pop_a;
  endtask

  task automatic test_restart;
    send_a(6'd63, 1'b1, 1'b0);
    send_a(6'd63, 1'b0, 1'b0);
    send_a(6'd2, 1'b1, 1'b1);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_res !== 9'd2 || a_out_len !== 8'd1) begin
      failures++; $display("FAIL restart actual v=%b res=%0d len=%0d required v=1 res=2 len=1",
                           a_out_valid, a_out_res, a_out_len);
    end
    pop_a;
    // No in_first on an IDLE digit still opens a fresh operand.
    send_a(6'd1, 1'b0, 1'b0);
    send_a(6'd3, 1'b0, 1'b1);
    checks++;
    if (a_out_res !== 9'd67 || a_out_len !== 8'd2) begin
      failures++; $display("FAIL idle_nofirst actual res=%0d len=%0d required res=67 len=2", a_out_res, a_out_len);
    end
    pop_a;
  endtask

  task automatic test_reset_mid;
    send_a(6'd63, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_res, a_out_len} !== {1'b0, 1'b1, 9'd0, 8'd0}) begin
      failures++; $display("FAIL reset_mid actual v=%b rdy=%b res=%0d len=%0d required v=0 rdy=1 res=0 len=0",
                           a_out_valid, a_in_ready, a_out_res, a_out_len);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(6'd9, 1'b1, 1'b1);
    checks++;
    if (a_out_valid !== 1'b1 || a_out_res !== 9'd9 || a_out_len !== 8'd1) begin
      failures++; $display("FAIL after_reset actual v=%b res=%0d len=%0d required v=1 res=9 len=1",
                           a_out_valid, a_out_res, a_out_len);
    end
    // Reset while the result is pending.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_out_valid, a_in_ready, a_out_res, a_out_len} !== {1'b0, 1'b1, 9'd0, 8'd0}) begin
      failures++; $display("FAIL reset_done actual v=%b rdy=%b res=%0d len=%0d required v=0 rdy=1 res=0 len=0",
                           a_out_valid, a_in_ready, a_out_res, a_out_len);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_saturation;
    int r;
    r = 0;
    for (int j = 0; j < 300; j++) begin
      r = (r * 64 + 63) % 461;
      send_a(6'd63, j == 0, j == 299);
    end
    checks++;
    if (a_out_valid !== 1'b1 || a_out_res !== 9'(r) || a_out_len !== 8'd255) begin
      failures++; $display("FAIL saturation actual v=%b res=%0d len=%0d required v=1 res=%0d len=255",
                           a_out_valid, a_out_res, a_out_len, r);
    end
    pop_a;
  endtask

  task automatic test_small_mod;
    int          nd  [4] = '{1, 2, 1, 3};
    logic [3:0]  dg  [4][3] = '{'{4'd15, 4'd0, 4'd0}, '{4'd14, 4'd5, 4'd0},
                                '{4'd4, 4'd0, 4'd0}, '{4'd2, 4'd2, 4'd1}};
    logic [1:0]  exr [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
    b_out_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      for (int j = 0; j < nd[op]; j++) begin
        send_b(dg[op][j], j == 0, j == nd[op] - 1);
      end
      checks++;
      if (b_out_valid !== 1'b1 || b_out_res !== exr[op] || b_out_len !== 4'(nd[op])) begin
        failures++;
        $display("FAIL small_op%0d actual v=%b res=%0d len=%0d required v=1 res=%0d len=%0d",
                 op, b_out_valid, b_out_res, b_out_len, exr[op], nd[op]);
      end
      @(posedge clk); #1;
    end
    // 20 digits of 1: 16 = 1 mod 3, so residue is 20 mod 3 = 2; length saturates at 15.
    for (int j = 0; j < 20; j++) begin
      send_b(4'd1, j == 0, j == 19);
    end
    checks++;
    if (b_out_valid !== 1'b1 || b_out_res !== 2'd2 || b_out_len !== 4'd15) begin
      failures++; $display("FAIL small_saturation actual v=%b res=%0d len=%0d required v=1 res=2 len=15",
                           b_out_valid, b_out_res, b_out_len);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_digit = '0; a_in_first = 1'b0; a_in_last = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_digit = '0; b_in_first = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_restart;
    test_reset_mid;
    test_saturation;
    test_small_mod;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
